// File: rtl/imm_decode_stage_if.sv
// Handshake bundle between fetch, the immediate-decode stage and register-read.
// The slave side belongs to the decode stage; the master side is its environment.
interface imm_decode_stage_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_instr
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_instr
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: combinational RV32/RV64 immediate decode feeding a
// 2-entry output buffer with valid/ready on both sides, flush and an illegal counter.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    imm_decode_stage_if.slave    bus,
    output logic [CNT_W-1:0]     illegal_cnt
);
    localparam bit IS_RV64 = (XLEN == 64);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // ---------------- combinational decode ----------------
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic            sgn;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign sgn    = instr[31];

    assign imm_i = {{(XLEN-12){sgn}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    // sign bit of U is instr[31] itself; the replication covers bits XLEN-1..31
    assign imm_u = {{(XLEN-31){sgn}}, instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_z = {{(XLEN-5){1'b0}}, instr[19:15]};

    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            unique case (opcode)
                OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
                    dec_imm = imm_i;
                    dec_fmt = FMT_I;
                end
                OPC_SYSTEM: begin
                    if (instr[14]) begin
                        dec_imm = imm_z;
                        dec_fmt = FMT_Z;
                    end else begin
                        dec_imm = imm_i;
                        dec_fmt = FMT_I;
                    end
                end
                OPC_OP_IMM_32: begin
                    if (IS_RV64) begin
                        dec_imm = imm_i;
                        dec_fmt = FMT_I;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OPC_STORE: begin
                    dec_imm = imm_s;
                    dec_fmt = FMT_S;
                end
                OPC_BRANCH: begin
                    dec_imm = imm_b;
                    dec_fmt = FMT_B;
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_imm = imm_u;
                    dec_fmt = FMT_U;
                end
                OPC_JAL: begin
                    dec_imm = imm_j;
                    dec_fmt = FMT_J;
                end
                OPC_OP: begin
                    dec_fmt = FMT_NONE;
                end
                OPC_OP_32: begin
                    dec_illegal = !IS_RV64;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    // ---------------- 2-entry output buffer ----------------
    logic [1:0]      count;
    logic            head;
    logic            tail;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] imm_q   [2];
    logic [2:0]      fmt_q   [2];
    logic            ill_q   [2];
    logic [XLEN-1:0] pc_q    [2];
    logic [31:0]     instr_q [2];

    // in_ready depends only on registered state, never on out_ready
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.out_valid && bus.out_ready;

    assign bus.out_imm     = imm_q[head];
    assign bus.out_fmt     = fmt_q[head];
    assign bus.out_illegal = ill_q[head];
    assign bus.out_pc      = pc_q[head];
    assign bus.out_instr   = instr_q[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i]   <= '0;
                fmt_q[i]   <= FMT_NONE;
                ill_q[i]   <= 1'b0;
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (push) begin
            imm_q[tail]   <= dec_imm;
            fmt_q[tail]   <= dec_fmt;
            ill_q[tail]   <= dec_illegal;
            pc_q[tail]    <= bus.in_pc;
            instr_q[tail] <= instr;
        end
    end

    // a pop in a flush cycle is still a delivery, so it is counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (pop && ill_q[head] && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: three instances (RV32, RV64, RV32 with 2-bit
// counter) share one stimulus stream and are checked against hand-computed values.
module tb_imm_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_ready;
    logic [15:0] cnt32;
    logic [15:0] cnt64;
    logic [1:0]  cnt2;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) b32 ();
    imm_decode_stage_if #(.XLEN(64)) b64 ();
    imm_decode_stage_if #(.XLEN(32)) bc2 ();

    assign b32.in_valid = in_valid;  assign b64.in_valid = in_valid;  assign bc2.in_valid = in_valid;
    assign b32.in_instr = in_instr;  assign b64.in_instr = in_instr;  assign bc2.in_instr = in_instr;
    assign b32.in_pc = in_pc[31:0];  assign b64.in_pc = in_pc;        assign bc2.in_pc = in_pc[31:0];
    assign b32.out_ready = out_ready; assign b64.out_ready = out_ready; assign bc2.out_ready = out_ready;

    imm_decode_stage #(.XLEN(32), .CNT_W(16)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b32.slave), .illegal_cnt(cnt32));
    imm_decode_stage #(.XLEN(64), .CNT_W(16)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b64.slave), .illegal_cnt(cnt64));
    imm_decode_stage #(.XLEN(32), .CNT_W(2)) uc2 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bc2.slave), .illegal_cnt(cnt2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // head of the RV32 instance
    task automatic chk_head32(input string tag, input logic v, input logic [31:0] imm,
                              input logic [2:0] fmt, input logic ill);
        chk({tag, ".valid"}, 64'(b32.out_valid), 64'(v));
        chk({tag, ".imm"}, 64'(b32.out_imm), 64'(imm));
        chk({tag, ".fmt"}, 64'(b32.out_fmt), 64'(fmt));
        chk({tag, ".ill"}, 64'(b32.out_illegal), 64'(ill));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 64'h0; out_ready = 1'b1;
        #2;
        chk("rst.out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst.in_ready", 64'(b32.in_ready), 64'd1);
        chk("rst.out_imm", 64'(b32.out_imm), 64'd0);
        chk("rst.cnt", 64'(cnt32), 64'd0);
        #10 rst = 1'b0;
        step();

        // addi x1,x0,-1
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h0000_0001_0000_0100;
        step();
        chk_head32("addi", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0);
        chk("addi.pc32", 64'(b32.out_pc), 64'h100);
        chk("addi.pc64", b64.out_pc, 64'h0000_0001_0000_0100);
        chk("addi.imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

        // back-to-back stream at full throughput
        in_instr = 32'hFE112E23; step();
        chk_head32("sw", 1'b1, 32'hFFFFFFFC, 3'd2, 1'b0);
        in_instr = 32'hFF9FF06F; step();
        chk_head32("jal", 1'b1, 32'hFFFFFFF8, 3'd5, 1'b0);
        chk("jal.imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        in_instr = 32'h300FD073; step();
        chk_head32("csrrwi", 1'b1, 32'h0000001F, 3'd6, 1'b0);
        chk("csrrwi.instr", 64'(b32.out_instr), 64'h300FD073);
        in_instr = 32'hFE000EE3; step();
        chk_head32("beq", 1'b1, 32'hFFFFFFFC, 3'd3, 1'b0);
        in_instr = 32'h800002B7; step();
        chk_head32("lui32", 1'b1, 32'h80000000, 3'd4, 1'b0);
        chk("lui.imm64", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui.fmt64", 64'(b64.out_fmt), 64'd4);
        in_instr = 32'h002081B3; step();
        chk_head32("add", 1'b1, 32'h0, 3'd0, 1'b0);
        in_valid = 1'b0; step();
        chk("drain.valid", 64'(b32.out_valid), 64'd0);
        chk("drain.cnt", 64'(cnt32), 64'd0);

        // illegal encodings: compressed, and RV64-only opcodes on RV32
        in_valid = 1'b1; in_instr = 32'h00000001; step();
        chk_head32("cmp", 1'b1, 32'h0, 3'd0, 1'b1);
        chk("cmp.ill64", 64'(b64.out_illegal), 64'd1);
        in_instr = 32'h0010009B; step();
        chk_head32("addiw32", 1'b1, 32'h0, 3'd0, 1'b1);
        chk("addiw.imm64", b64.out_imm, 64'd1);
        chk("addiw.fmt64", 64'(b64.out_fmt), 64'd1);
        chk("addiw.ill64", 64'(b64.out_illegal), 64'd0);
        chk("ill.cnt1", 64'(cnt32), 64'd1);
        in_instr = 32'h0020803B; step();
        chk_head32("addw32", 1'b1, 32'h0, 3'd0, 1'b1);
        chk("addw.ill64", 64'(b64.out_illegal), 64'd0);
        chk("ill.cnt2", 64'(cnt32), 64'd2);
        in_valid = 1'b0; step();
        chk("ill.cnt3", 64'(cnt32), 64'd3);
        chk("ill.cnt64", 64'(cnt64), 64'd1);
        chk("ill.cnt2b", 64'(cnt2), 64'd3);
        in_valid = 1'b1; in_instr = 32'h00000001; step(); step();
        in_valid = 1'b0; step();
        chk("sat.cnt32", 64'(cnt32), 64'd5);
        chk("sat.cnt2b", 64'(cnt2), 64'd3);

        // back-pressure: two accepts, third held, then in-order drain
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; step();
        chk("bp.rdy1", 64'(b32.in_ready), 64'd1);
        chk_head32("bp.a", 1'b1, 32'd5, 3'd1, 1'b0);
        in_instr = 32'h00600113; step();
        chk("bp.rdy2", 64'(b32.in_ready), 64'd0);
        chk_head32("bp.a2", 1'b1, 32'd5, 3'd1, 1'b0);
        in_instr = 32'h00700193; step();
        chk("bp.rdy3", 64'(b32.in_ready), 64'd0);
        chk("bp.a3.instr", 64'(b32.out_instr), 64'h00500093);
        out_ready = 1'b1; step();
        chk_head32("bp.b", 1'b1, 32'd6, 3'd1, 1'b0);
        chk("bp.rdy4", 64'(b32.in_ready), 64'd1);
        step();
        chk_head32("bp.c", 1'b1, 32'd7, 3'd1, 1'b0);
        in_valid = 1'b0; step();
        chk("bp.empty", 64'(b32.out_valid), 64'd0);

        // flush while full, with an input presented in the flush cycle
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00800093; step();
        in_instr = 32'h00900093; step();
        chk("fl.full", 64'(b32.in_ready), 64'd0);
        flush = 1'b1; in_instr = 32'h00A00093; step();
        chk("fl.valid", 64'(b32.out_valid), 64'd0);
        chk("fl.rdy", 64'(b32.in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        chk("fl.dropped", 64'(b32.out_valid), 64'd0);

        // pop in the flush cycle still counts
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000001; step();
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1; step();
        flush = 1'b0;
        chk("fl.popcnt", 64'(cnt32), 64'd6);
        chk("fl.popvalid", 64'(b32.out_valid), 64'd0);

        // asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h200; step();
        chk("ar.pre", 64'(b32.out_valid), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("ar.valid", 64'(b32.out_valid), 64'd0);
        chk("ar.imm", 64'(b32.out_imm), 64'd0);
        chk("ar.pc", 64'(b32.out_pc), 64'd0);
        chk("ar.instr", 64'(b32.out_instr), 64'd0);
        chk("ar.cnt", 64'(cnt32), 64'd0);
        chk("ar.rdy", 64'(b32.in_ready), 64'd1);
        step();
        chk("ar.ignored", 64'(b32.out_valid), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode pipeline stage for the RISC-V core. It sits between fetch and the register-read/execute stage. Each accepted instruction is decoded into an XLEN-wide sign-extended immediate, a format code and an illegal flag, and the result is held in a 2-entry output buffer with valid/ready handshakes on both sides. Compared with the plain combinational immediate generator, it adds:
- RV64 support
- CSR-immediate (zimm) decoding
- illegal-encoding detection
- back-pressure and flush
- a saturating illegal-instruction counter

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64 only.
- CNT_W, 16, width of the illegal-instruction counter.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept; equals (count < 2); no combinational path from out_ready.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address; passed through unchanged.
- flush  in  1  synchronous kill of all buffered entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 reserved (never driven).
- out_illegal  out  1  unsupported encoding.
- out_pc  out  XLEN  PC of the head entry.
- out_instr  out  32  instruction word of the head entry.
- illegal_cnt  out  CNT_W  saturating count of illegal entries delivered.

## Operation
- Decode is combinational on the input side. The decoded fields, PC and instruction are written into the buffer on accept (in_valid && in_ready && !flush).
- All sign extension is from instr[31] to XLEN.

Format by opcode (instr[6:0]):
- I: 0010011, 0000011, 1100111, 0001111, and 1110011 with funct3[2]=0. Also 0011011 (OP-IMM-32), but only when XLEN=64.
- S: 0100011.
- B: 1100011.
- U: 0110111, 0010111. imm = {instr[31:12], 12'b0}, sign-extended to XLEN.
- J: 1101111.
- Z: 1110011 with funct3[2]=1. imm = zero-extended instr[19:15].
- NONE: 0110011, and 0111011 when XLEN=64. imm = 0, not illegal.

Illegal:
- Condition: instr[1:0] != 2'b11, any other opcode, or an RV64-only opcode when XLEN=32.
- Result: out_fmt = NONE, out_imm = 0, out_illegal = 1.

Buffer:
- 2-entry FIFO with count in 0..2, a head pointer and a tail pointer, each 1 bit.
- Push on accept; pop on out_valid && out_ready.
- Push and pop in the same cycle leaves count unchanged; both pointers advance.
- out_valid = (count != 0). Output fields come directly from the head entry's registers.

illegal_cnt:
- Increments on each pop whose entry has illegal=1.
- Saturates at 2^CNT_W-1.
- Cleared only by rst.

Flush:
- Next cycle count = 0 and pointers = 0.
- An input presented in the flush cycle is dropped.
- A pop in the flush cycle still counts toward illegal_cnt.

## Timing
- Latency: an instruction accepted at edge N is presented with out_valid=1 after edge N; out_valid is asserted 1 cycle after acceptance.
- Throughput: 1 instruction per cycle while out_ready=1.
- Back-pressure: with out_ready=0, two entries are accepted and then in_ready=0 until a pop occurs. When full, in_ready=0, so there is no push even if out_ready=1 that cycle. in_ready returns to 1 the cycle after the pop.
- Output stability: head fields are stable while out_valid && !out_ready.

Reset (asynchronous; state forced immediately):
- count=0, pointers=0, out_valid=0, in_ready=1, illegal_cnt=0.
- out_imm, out_fmt, out_illegal, out_pc and out_instr reset to 0.
- Inputs are ignored while rst=1.
- Reset mid-operation discards all buffered entries.

## Test plan
- XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> after 1 cycle: out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- Back-to-back sequence 0xFE112E23 (sw -4), then 0xFF9FF06F (jal -8), then 0x300FD073 (csrrwi 31) -> out_imm = 0xFFFFFFFC / fmt 2, then 0xFFFFFFF8 / fmt 5, then 0x0000001F / fmt 6, on consecutive cycles.
- XLEN=64, in_instr=0x800002B7 (lui x5,0x80000) -> out_imm=0xFFFFFFFF80000000, fmt 4.
- out_ready=0, three consecutive valid inputs -> in_ready drops to 0 after 2 accepts, the third input is held; raising out_ready drains entries in order with no loss or duplication.
- Input 0x00000001 (compressed encoding), then opcode 0011011 with XLEN=32 -> both entries out_illegal=1, out_imm=0, out_fmt=0; illegal_cnt=2 after both pop. With CNT_W=2, 5 illegal pops -> illegal_cnt=3.
- Buffer holds 2 entries; assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the flush-cycle input is never output. Assert rst asynchronously mid-stream -> outputs are 0 immediately.
